// File: rtl/video_pattern_gen.sv
// video_pattern_gen: pixel source behind video_timing. Rebuilds the active-area
// x/y position from the timing strobes and paints one of four 24-bit test
// patterns. The sync, DE and colour outputs share a fixed two-clock latency.
module video_pattern_gen #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int BAR_W       = 160,
  parameter int CHECK_SHIFT = 5,
  parameter int XW          = 11,
  parameter int YW          = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        visible_in,
  input  logic [1:0]  mode,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [23:0] rgb
);

  localparam int             BCW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);
  localparam logic [XW-1:0]  X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(V_ACTIVE - 1);

  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Stage 1 state: captured strobes, position and per-frame attributes
  logic           hsync_p1_q, hsync_p1_d;
  logic           vsync_p1_q, vsync_p1_d;
  logic           vld_p1_q, vld_p1_d;
  logic [XW-1:0]  x_p1_q, x_p1_d;
  logic [YW-1:0]  y_p1_q, y_p1_d;
  logic [BCW-1:0] bar_cnt_p1_q, bar_cnt_p1_d;
  logic [2:0]     bar_idx_p1_q, bar_idx_p1_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic [1:0]     mode_q, mode_d;
  logic           synced_q, synced_d;

  // Stage 2 state: registered outputs
  logic           hsync_p2_q, hsync_p2_d;
  logic           vsync_p2_q, vsync_p2_d;
  logic           vld_p2_q, vld_p2_d;
  logic [23:0]    rgb_p2_q, rgb_p2_d;

  logic           vs_rise;
  logic           vis_fall;
  logic           in_line;

  // Stage 1: edge detection, x/y counters, bar tracking and frame-start updates
  always_comb begin
    vs_rise      = vsync_in & ~vsync_p1_q;
    vis_fall     = vld_p1_q & ~visible_in;
    // A pixel continues the current line only if the previous cycle was active too
    in_line      = visible_in & vld_p1_q;

    hsync_p1_d   = hsync_in;
    vsync_p1_d   = vsync_in;
    vld_p1_d     = visible_in;

    x_p1_d       = '0;
    bar_cnt_p1_d = '0;
    bar_idx_p1_d = 3'd0;
    if (in_line) begin
      x_p1_d = sat_inc_x(x_p1_q);
      if (bar_cnt_p1_q == BAR_LAST) begin
        bar_cnt_p1_d = '0;
        bar_idx_p1_d = (bar_idx_p1_q == 3'd7) ? 3'd7 : bar_idx_p1_q + 3'd1;
      end else begin
        bar_cnt_p1_d = bar_cnt_p1_q + 1'b1;
        bar_idx_p1_d = bar_idx_p1_q;
      end
    end

    // Frame-start clear takes priority over an end-of-line increment
    y_p1_d = y_p1_q;
    if (vs_rise) begin
      y_p1_d = '0;
    end else if (vis_fall) begin
      y_p1_d = sat_inc_y(y_p1_q);
    end

    // The first frame after reset is frame 0, so counting starts once synced
    frame_cnt_d = (vs_rise && synced_q) ? frame_cnt_q + 8'd1 : frame_cnt_q;
    mode_d      = vs_rise ? mode : mode_q;
    synced_d    = synced_q | vs_rise;
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_p1_q   <= 1'b0;
      vsync_p1_q   <= 1'b0;
      vld_p1_q     <= 1'b0;
      x_p1_q       <= '0;
      y_p1_q       <= '0;
      bar_cnt_p1_q <= '0;
      bar_idx_p1_q <= 3'd0;
      frame_cnt_q  <= 8'd0;
      mode_q       <= 2'd0;
      synced_q     <= 1'b0;
    end else begin
      hsync_p1_q   <= hsync_p1_d;
      vsync_p1_q   <= vsync_p1_d;
      vld_p1_q     <= vld_p1_d;
      x_p1_q       <= x_p1_d;
      y_p1_q       <= y_p1_d;
      bar_cnt_p1_q <= bar_cnt_p1_d;
      bar_idx_p1_q <= bar_idx_p1_d;
      frame_cnt_q  <= frame_cnt_d;
      mode_q       <= mode_d;
      synced_q     <= synced_d;
    end
  end

  // Stage 2: pattern colour select, blanked outside active video or before sync
  always_comb begin
    logic [23:0] colour;
    colour = 24'h000000;
    case (mode_q)
      2'd0: colour = bar_colour(bar_idx_p1_q);
      2'd1: colour = (x_p1_q[CHECK_SHIFT] ^ y_p1_q[CHECK_SHIFT]) ? 24'h000000 : 24'hFFFFFF;
      2'd2: colour = {x_p1_q[7:0], y_p1_q[7:0], frame_cnt_q};
      default: begin
        if (x_p1_q == '0 || x_p1_q == X_LAST || y_p1_q == '0 || y_p1_q == Y_LAST) begin
          colour = 24'hFFFFFF;
        end else if (x_p1_q[5:0] == 6'd0 || y_p1_q[5:0] == 6'd0) begin
          colour = 24'h808080;
        end else begin
          colour = 24'h000040;
        end
      end
    endcase

    hsync_p2_d = hsync_p1_q;
    vsync_p2_d = vsync_p1_q;
    vld_p2_d   = vld_p1_q;
    rgb_p2_d   = (synced_q && vld_p1_q) ? colour : 24'h000000;
  end

  // Stage 2 registers drive the pins directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_p2_q <= 1'b0;
      vsync_p2_q <= 1'b0;
      vld_p2_q   <= 1'b0;
      rgb_p2_q   <= 24'h000000;
    end else begin
      hsync_p2_q <= hsync_p2_d;
      vsync_p2_q <= vsync_p2_d;
      vld_p2_q   <= vld_p2_d;
      rgb_p2_q   <= rgb_p2_d;
    end
  end

  assign hsync_out = hsync_p2_q;
  assign vsync_out = vsync_p2_q;
  assign de_out    = vld_p2_q;
  assign rgb       = rgb_p2_q;

endmodule
